// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin bus arbiter.
// Grants one master per transfer with address decode, completion wait and timeout.
module bus_arbiter_rr #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_SLAVES     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_req,
  input  logic        m2_req,
  input  logic [13:0] m1_addr,
  input  logic [13:0] m2_addr,
  input  logic        bus_done,
  output logic        m1_grant,
  output logic        m2_grant,
  output logic        bus_start,
  output logic [1:0]  slave_sel,
  output logic        addr_err,
  output logic        timeout,
  output logic        busy
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner_m2;
  logic          r_last_m2;
  logic          r_m1_grant;
  logic          r_m2_grant;
  logic          r_bus_start;
  logic          r_addr_err;
  logic          r_timeout;
  logic          r_busy;
  logic [1:0]    r_sel;

  logic [1:0]    w_nstate;
  logic [CW-1:0] w_cnt;
  logic          w_owner_m2;
  logic          w_last_m2;
  logic          w_m1_grant;
  logic          w_m2_grant;
  logic          w_bus_start;
  logic          w_addr_err;
  logic          w_timeout;
  logic [1:0]    w_sel;
  logic          w_win_m2;
  logic [1:0]    w_win_idx;
  logic          w_idx_ok;
  logic          w_tc;

  // On a tie the master not served last wins.
  always_comb begin
    w_win_m2 = 1'b0;
    unique case (1'b1)
      (m1_req && m2_req):  w_win_m2 = ~r_last_m2;
      (!m1_req && m2_req): w_win_m2 = 1'b1;
      default:             w_win_m2 = 1'b0;
    endcase
  end

  assign w_win_idx = w_win_m2 ? m2_addr[13:12]
                              : m1_addr[13:12];
  assign w_idx_ok  =
    ({30'd0, w_win_idx} < 32'(NUM_SLAVES));
  assign w_tc = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_nstate    = r_state;
    w_cnt       = r_cnt;
    w_owner_m2  = r_owner_m2;
    w_last_m2   = r_last_m2;
    w_m1_grant  = r_m1_grant;
    w_m2_grant  = r_m2_grant;
    w_bus_start = 1'b0;
    w_addr_err  = 1'b0;
    w_timeout   = 1'b0;
    w_sel       = r_sel;
    unique case (r_state)
      IDLE: begin
        if (m1_req || m2_req) begin
          w_nstate    = GRANT;
          w_owner_m2  = w_win_m2;
          w_sel       = w_win_idx;
          w_m1_grant  = ~w_win_m2;
          w_m2_grant  = w_win_m2;
          w_bus_start = w_idx_ok;
          w_addr_err  = ~w_idx_ok;
        end
      end
      GRANT: begin
        // r_addr_err marks a grant to an undecoded slave.
        if (r_addr_err) begin
          w_nstate   = RELEASE;
          w_m1_grant = 1'b0;
          w_m2_grant = 1'b0;
        end else begin
          w_nstate = WAIT;
        end
      end
      WAIT: begin
        if (bus_done) begin
          w_nstate   = RELEASE;
          w_m1_grant = 1'b0;
          w_m2_grant = 1'b0;
        end else if (w_tc) begin
          w_nstate   = RELEASE;
          w_timeout  = 1'b1;
          w_m1_grant = 1'b0;
          w_m2_grant = 1'b0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      RELEASE: begin
        w_nstate   = IDLE;
        w_cnt      = '0;
        w_last_m2  = r_owner_m2;
        w_m1_grant = 1'b0;
        w_m2_grant = 1'b0;
      end
      default: begin
        w_nstate   = IDLE;
        w_cnt      = '0;
        w_m1_grant = 1'b0;
        w_m2_grant = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner_m2  <= 1'b0;
      r_last_m2   <= 1'b1;
      r_m1_grant  <= 1'b0;
      r_m2_grant  <= 1'b0;
      r_bus_start <= 1'b0;
      r_addr_err  <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_sel       <= 2'd0;
    end else begin
      r_state     <= w_nstate;
      r_cnt       <= w_cnt;
      r_owner_m2  <= w_owner_m2;
      r_last_m2   <= w_last_m2;
      r_m1_grant  <= w_m1_grant;
      r_m2_grant  <= w_m2_grant;
      r_bus_start <= w_bus_start;
      r_addr_err  <= w_addr_err;
      r_timeout   <= w_timeout;
      r_busy      <= (w_nstate != IDLE);
      r_sel       <= w_sel;
    end
  end

  assign m1_grant  = r_m1_grant;
  assign m2_grant  = r_m2_grant;
  assign bus_start = r_bus_start;
  assign addr_err  = r_addr_err;
  assign timeout   = r_timeout;
  assign busy      = r_busy;
  assign slave_sel = r_sel;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr.
// One task per scenario, inline checks, grant exclusion watched every cycle.
module tb_bus_arbiter_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic        m1_req, m2_req;
  logic [13:0] m1_addr, m2_addr;
  logic        bus_done;
  logic        m1_grant, m2_grant;
  logic        bus_start;
  logic [1:0]  slave_sel;
  logic        addr_err, timeout, busy;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter_rr dut (
    .clk       (clk),
    .reset     (reset),
    .m1_req    (m1_req),
    .m2_req    (m2_req),
    .m1_addr   (m1_addr),
    .m2_addr   (m2_addr),
    .bus_done  (bus_done),
    .m1_grant  (m1_grant),
    .m2_grant  (m2_grant),
    .bus_start (bus_start),
    .slave_sel (slave_sel),
    .addr_err  (addr_err),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_tests++;
    if (m1_grant && m2_grant) begin
      n_fail++;
      $display("FAIL mutex: m1_grant=%b m2_grant=%b required not both 1",
               m1_grant, m2_grant);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m1_req = 0; m2_req = 0; bus_done = 0;
    m1_addr = '0; m2_addr = '0;
    #3;
    n_tests++;
    if ({m1_grant, m2_grant, bus_start, addr_err, timeout, busy,
         slave_sel} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b required 00000000",
               {m1_grant, m2_grant, bus_start, addr_err, timeout, busy,
                slave_sel});
    end
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single();
    m1_req = 1; m1_addr = 14'd1001;
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, bus_start, busy, slave_sel}
        !== 6'b101100) begin
      n_fail++;
      $display("FAIL single_grant: got %b required 101100",
               {m1_grant, m2_grant, bus_start, busy, slave_sel});
    end
    m1_req = 0;
    tick();
    n_tests++;
    if ({m1_grant, bus_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_wait: grant,start=%b required 10",
               {m1_grant, bus_start});
    end
    repeat (9) tick();
    bus_done = 1;
    tick();
    bus_done = 0;
    n_tests++;
    if ({m1_grant, busy, timeout} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_release: grant,busy,to=%b required 010",
               {m1_grant, busy, timeout});
    end
    tick();
    n_tests++;
    if ({m1_grant, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: grant,busy=%b required 00",
               {m1_grant, busy});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m1_req = 1; m2_req = 1;
    m1_addr = 14'd5097; m2_addr = 14'd5098;
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, slave_sel} !== 4'b1001) begin
      n_fail++;
      $display("FAIL rr_first: got %b required 1001",
               {m1_grant, m2_grant, slave_sel});
    end
    tick();
    m1_addr = 14'd12288;
    bus_done = 1;
    n_tests++;
    if (slave_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL rr_addr_hold: slave_sel=%0d required 1", slave_sel);
    end
    tick();
    bus_done = 0;
    n_tests++;
    if ({m1_grant, m2_grant} !== 2'b00) begin
      n_fail++;
      $display("FAIL rr_gap1: grants=%b required 00", {m1_grant, m2_grant});
    end
    m1_addr = 14'd5097;
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_gap2: grants,busy=%b required 000",
               {m1_grant, m2_grant, busy});
    end
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, slave_sel, bus_start} !== 5'b01011) begin
      n_fail++;
      $display("FAIL rr_second: got %b required 01011",
               {m1_grant, m2_grant, slave_sel, bus_start});
    end
    m1_req = 0; m2_req = 0;
    tick();
    bus_done = 1;
    tick();
    bus_done = 0;
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_done: grants,busy=%b required 000",
               {m1_grant, m2_grant, busy});
    end
  endtask

  task automatic test_addr_err();
    m2_req = 1; m2_addr = 14'd12288;
    tick();
    m2_req = 0;
    n_tests++;
    if ({m2_grant, addr_err, bus_start, slave_sel} !== 5'b11011) begin
      n_fail++;
      $display("FAIL aerr_grant: grant,err,start,sel=%b required 11011",
               {m2_grant, addr_err, bus_start, slave_sel});
    end
    tick();
    n_tests++;
    if ({m2_grant, addr_err, bus_start, busy} !== 4'b0001) begin
      n_fail++;
      $display("FAIL aerr_release: grant,err,start,busy=%b required 0001",
               {m2_grant, addr_err, bus_start, busy});
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL aerr_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_timeout();
    m1_req = 1; m1_addr = 14'd0;
    tick();
    m1_req = 0;
    tick();
    repeat (63) tick();
    n_tests++;
    if ({m1_grant, timeout} !== 2'b10) begin
      n_fail++;
      $display("FAIL to_last_wait: grant,to=%b required 10",
               {m1_grant, timeout});
    end
    tick();
    n_tests++;
    if ({m1_grant, timeout, busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL to_pulse: grant,to,busy=%b required 011",
               {m1_grant, timeout, busy});
    end
    tick();
    n_tests++;
    if ({timeout, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL to_idle: to,busy=%b required 00", {timeout, busy});
    end
    m1_req = 1;
    tick();
    m1_req = 0;
    tick();
    repeat (63) tick();
    bus_done = 1;
    tick();
    bus_done = 0;
    n_tests++;
    if ({m1_grant, timeout, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL to_done_wins: grant,to,busy=%b required 001",
               {m1_grant, timeout, busy});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    m2_req = 1; m2_addr = 14'd0;
    tick();
    m2_req = 0;
    tick();
    tick();
    m1_req = 1; m1_addr = 14'd4096;
    n_tests++;
    if (m2_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: m2_grant=%b required 1", m2_grant);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({m1_grant, m2_grant, timeout, addr_err, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_async: got %b required 00000",
               {m1_grant, m2_grant, timeout, addr_err, busy});
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({m1_grant, m2_grant, slave_sel, bus_start} !== 5'b10011) begin
      n_fail++;
      $display("FAIL rst_resume: got %b required 10011",
               {m1_grant, m2_grant, slave_sel, bus_start});
    end
    m1_req = 0;
    tick();
    bus_done = 1;
    tick();
    bus_done = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_addr_err();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
